// File: rtl/mac_frame_pipe_if.sv
// Sample/result bus for mac_frame_pipe; the master drives samples and bias and the slave (the engine) returns results.
interface mac_frame_pipe_if #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) ();
  // Handshake: no backpressure. A sample is taken on a rising clk edge with en && in_valid.
  // out_valid is a one-cycle strobe; Result/out_count/out_ovf are meaningful while it is high.
  logic             en;
  logic             in_valid;
  logic             in_last;
  logic             signed_mode;
  logic [IN_W-1:0]  X;
  logic [IN_W-1:0]  Y;
  logic             acc_load;
  logic [ACC_W-1:0] Z;
  logic [ACC_W-1:0] Result;
  logic             out_valid;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             dbg_state;

  modport master (
    output en, in_valid, in_last, signed_mode, X, Y, acc_load, Z,
    input  Result, out_valid, out_count, out_ovf, dbg_state
  );

  modport slave (
    input  en, in_valid, in_last, signed_mode, X, Y, acc_load, Z,
    output Result, out_valid, out_count, out_ovf, dbg_state
  );
endinterface

// File: rtl/mac_frame_pipe.sv
// Framed multiply-accumulate: input tag stage, multiply, extend, accumulate.
// Define MAC_FRAME_SAT_EN to make the accumulate stage saturate instead of wrap.
module mac_frame_pipe #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  mac_frame_pipe_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic   accept, tag_first, tag_sgn;
  logic [ACC_W-1:0] bias_q, tag_bias;

  assign accept    = bus.en & bus.in_valid;
  assign tag_first = (state_q == IDLE);
  assign tag_sgn   = tag_first ? bus.signed_mode : mode_q;
  // Bias loaded in the same cycle as a first sample is used directly.
  assign tag_bias  = bus.acc_load ? bus.Z : bias_q;
  assign bus.dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (accept) begin
      if (state_q == IDLE) begin
        mode_d  = bus.signed_mode;
        state_d = bus.in_last ? IDLE : RUN;
      end else if (bus.in_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      bias_q  <= '0;
    end else if (bus.en) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      if (bus.acc_load) bias_q <= bus.Z;
    end
  end

  // Stage tags
  logic s0_valid, s0_first, s0_last, s0_sgn;
  logic s1_valid, s1_first, s1_last, s1_sgn;
  logic s2_valid, s2_first, s2_last, s2_sgn;
  logic [IN_W-1:0]    s0_x, s0_y;
  logic [ACC_W-1:0]   s0_bias, s1_bias, s2_bias;
  logic [2*IN_W-1:0]  s1_prod, prod_d;
  logic [ACC_W-1:0]   s2_ext, ext_d;

  // Sign-extending the operands lets one unsigned multiplier serve both modes.
  always_comb begin
    prod_d = {{IN_W{s0_sgn & s0_x[IN_W-1]}}, s0_x} * {{IN_W{s0_sgn & s0_y[IN_W-1]}}, s0_y};
  end

  always_comb begin
    ext_d = '0;
    ext_d[2*IN_W-1:0] = s1_prod;
    for (int i = 2*IN_W; i < ACC_W; i++) ext_d[i] = s1_sgn & s1_prod[2*IN_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {s0_valid, s0_first, s0_last, s0_sgn} <= '0;
      {s1_valid, s1_first, s1_last, s1_sgn} <= '0;
      {s2_valid, s2_first, s2_last, s2_sgn} <= '0;
      s0_x    <= '0;
      s0_y    <= '0;
      s0_bias <= '0;
      s1_bias <= '0;
      s2_bias <= '0;
      s1_prod <= '0;
      s2_ext  <= '0;
    end else if (bus.en) begin
      s0_valid <= accept;
      s0_first <= tag_first;
      s0_last  <= bus.in_last;
      s0_sgn   <= tag_sgn;
      s0_x     <= bus.X;
      s0_y     <= bus.Y;
      s0_bias  <= tag_bias;
      {s1_valid, s1_first, s1_last, s1_sgn} <= {s0_valid, s0_first, s0_last, s0_sgn};
      s1_bias  <= s0_bias;
      s1_prod  <= prod_d;
      {s2_valid, s2_first, s2_last, s2_sgn} <= {s1_valid, s1_first, s1_last, s1_sgn};
      s2_bias  <= s1_bias;
      s2_ext   <= ext_d;
    end
  end

  // Accumulate stage
  logic [ACC_W-1:0] acc_q, a_op, acc_d;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, vld_q, add_ovf;

  always_comb begin
    a_op    = s2_first ? s2_bias : acc_q;
    sum     = {1'b0, a_op} + {1'b0, s2_ext};
    add_ovf = s2_sgn ? ((a_op[ACC_W-1] == s2_ext[ACC_W-1]) && (sum[ACC_W-1] != a_op[ACC_W-1]))
                     : sum[ACC_W];
    acc_d   = sum[ACC_W-1:0];
`ifdef MAC_FRAME_SAT_EN
    if (add_ovf) begin
      if (!s2_sgn)              acc_d = '1;
      else if (a_op[ACC_W-1])   acc_d = {1'b1, {(ACC_W-1){1'b0}}};
      else                      acc_d = {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (!bus.en) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= s2_valid & s2_last;
      if (s2_valid) begin
        acc_q <= acc_d;
        if (s2_first) begin
          cnt_q <= CNT_W'(1);
          ovf_q <= add_ovf;
        end else begin
          cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          ovf_q <= ovf_q | add_ovf;
        end
      end
    end
  end

  assign bus.Result    = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_mac_frame_pipe.sv
// Directed scoreboard bench for mac_frame_pipe (IN_W=8, ACC_W=16, CNT_W=4).
module tb_mac_frame_pipe;
  localparam int IN_W  = 8;
  localparam int ACC_W = 16;
  localparam int CNT_W = 4;
  localparam int EW    = 1 + CNT_W + ACC_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [EW-1:0] exp_q[$];

  mac_frame_pipe_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mac_frame_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input int r, input int c, input logic o);
    return {o, CNT_W'(c), ACC_W'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step(input logic e, input logic v, input logic l, input logic sm,
                      input logic ld, input int x, input int y, input int z);
    bus.en          = e;
    bus.in_valid    = v;
    bus.in_last     = l;
    bus.signed_mode = sm;
    bus.acc_load    = ld;
    bus.X           = IN_W'(x);
    bus.Y           = IN_W'(y);
    bus.Z           = ACC_W'(z);
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int x, input int y, input logic l, input logic sm);
    step(1'b1, 1'b1, l, sm, 1'b0, x, y, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got Result=0x%0h count=%0d with nothing expected",
                 bus.Result, bus.out_count);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("result", 32'(bus.Result),    32'(e[ACC_W-1:0]));
        chk("count",  32'(bus.out_count), 32'(e[ACC_W +: CNT_W]));
        chk("ovf",    32'(bus.out_ovf),   32'(e[EW-1]));
      end
    end
  end

  initial begin
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.signed_mode = 1'b0;
    bus.acc_load = 1'b0; bus.X = '0; bus.Y = '0; bus.Z = '0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("reset_result",    32'(bus.Result),    32'd0);
    chk("reset_count",     32'(bus.out_count), 32'd0);
    chk("reset_ovf",       32'(bus.out_ovf),   32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);

    // Signed frame with preloaded bias 100: 100+12-10-7
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 100);
    samp(3, 4, 1'b0, 1'b1);
    samp(-2, 5, 1'b0, 1'b1);
    exp_q.push_back(mk(95, 3, 1'b0));
    samp(7, -1, 1'b1, 1'b1);

    // Unsigned single sample, bias 0 loaded in the same cycle
    exp_q.push_back(mk(65025, 1, 1'b0));
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 255, 255, 0);
    exp_q.push_back(mk(1, 1, 1'b0));
    samp(-1, -1, 1'b1, 1'b1);
    // Mode toggled mid-frame stays unsigned: 510 + 255
    samp(255, 2, 1'b0, 1'b0);
    exp_q.push_back(mk(765, 2, 1'b0));
    samp(255, 1, 1'b1, 1'b1);

`ifdef MAC_FRAME_SAT_EN
    exp_q.push_back(mk(32'h7FFF, 1, 1'b1));
    exp_q.push_back(mk(32'h8000, 1, 1'b1));
    exp_q.push_back(mk(32'hFFFF, 1, 1'b1));
    exp_q.push_back(mk(32'h7FFF, 2, 1'b1));
`else
    exp_q.push_back(mk(32'h8000, 1, 1'b1));
    exp_q.push_back(mk(32'h7FFF, 1, 1'b1));
    exp_q.push_back(mk(32'hFE00, 1, 1'b1));
    exp_q.push_back(mk(32'h8000, 2, 1'b1));
`endif
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1, 32767);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1, -32768);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 255, 255, 65535);
    // Sticky overflow: second add does not overflow
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1, 32767);
    samp(0, 0, 1'b1, 1'b1);

    // Stall of two cycles mid-frame; the frozen inputs must not be taken
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 100);
    samp(3, 4, 1'b0, 1'b1);
    samp(-2, 5, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 99, 99, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 99, 99, 0);
    exp_q.push_back(mk(95, 3, 1'b0));
    samp(7, -1, 1'b1, 1'b1);

    // Strobe followed by en=0 cycles must pulse once
    exp_q.push_back(mk(104, 1, 1'b0));
    samp(2, 2, 1'b1, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    idle(6);

    // Reset aborts an open frame and clears the bias
    samp(5, 5, 1'b0, 1'b1);
    samp(6, 6, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.push_back(mk(6, 1, 1'b0));
    samp(2, 3, 1'b1, 1'b1);

    // Back-to-back single-sample frames, bias 10
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 10);
    exp_q.push_back(mk(12, 1, 1'b0));
    exp_q.push_back(mk(22, 1, 1'b0));
    exp_q.push_back(mk(40, 1, 1'b0));
    samp(1, 2, 1'b1, 1'b0);
    samp(3, 4, 1'b1, 1'b0);
    samp(5, 6, 1'b1, 1'b0);

    // Term counter saturates at 15 over a 17-term frame
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0);
    for (int i = 0; i < 15; i++) samp(1, 1, 1'b0, 1'b0);
    exp_q.push_back(mk(17, 15, 1'b0));
    samp(1, 1, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      idle(1);
    end
    idle(6);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d strobes still outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
